// File: rtl/utf16_byte_encoder_if.sv
// Code-point-in / UTF-16-byte-out bus bundle for utf16_byte_encoder.
// Latency: n/a (wires only).
// Backpressure: cp side is valid/ready into the encoder, byte side is valid/ready out of it.
//
// Signals:
//   cp_valid, cp_data[31:0], be -> encoder ; cp_ready <- encoder
//   byte_valid, byte_data[7:0]  <- encoder ; byte_ready -> encoder
// Modports: slave = encoder view, master = producer/consumer environment view.
interface utf16_byte_encoder_if;
    logic        cp_valid;
    logic        cp_ready;
    logic [31:0] cp_data;
    logic        be;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;

    modport slave (
        input  cp_valid,
        input  cp_data,
        input  be,
        output cp_ready,
        output byte_valid,
        output byte_data,
        input  byte_ready
    );

    modport master (
        output cp_valid,
        output cp_data,
        output be,
        input  cp_ready,
        input  byte_valid,
        input  byte_data,
        output byte_ready
    );
endinterface

// File: rtl/utf16_byte_encoder.sv
// Serialises one Unicode code point into UTF-16 bytes (BE or LE), surrogate pairs above U+FFFF.
// Latency: first byte valid one cycle after accept; 2 bytes (BMP) or 4 bytes (supplementary), plus 1 idle bubble.
// Backpressure: byte_data/byte_valid hold while byte_ready is low; cp_ready only in IDLE, independent of byte_ready.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   bus (slave)       cp_valid/cp_ready/cp_data/be in, byte_valid/byte_ready/byte_data out
//   idle              no code point in progress
//   clr_err           synchronous clear of sticky error flags (a same-cycle new error wins)
//   err_range         sticky: code point above 0x10FFFF seen
//   err_surr          sticky: code point in 0xD800..0xDFFF seen
//   bom_req           (UTF16_BOM_EN only) re-arm the byte-order mark for the next accept
// Build option: define UTF16_BOM_EN to prefix the first code point after reset (or after
// bom_req) with a byte-order mark, sent from states BOM0/BOM1.
module utf16_byte_encoder (
    input  logic                      clk,
    input  logic                      rst,
    utf16_byte_encoder_if.slave       bus,
    output logic                      idle,
    input  logic                      clr_err,
    output logic                      err_range,
    output logic                      err_surr
`ifdef UTF16_BOM_EN
    ,
    input  logic                      bom_req
`endif
);

`ifdef UTF16_BOM_EN
    typedef enum logic [2:0] {IDLE, U0, U1, U2, U3, BOM0, BOM1} state_t;
`else
    typedef enum logic [2:0] {IDLE, U0, U1, U2, U3} state_t;
`endif

    state_t      r_state;
    logic [15:0] r_hi;          // first (or only) UTF-16 unit
    logic [15:0] r_lo;          // low surrogate, only meaningful when r_supp
    logic        r_supp;
    logic        r_be;
    logic        r_byte_valid;
    logic [7:0]  r_byte_data;
    logic        r_err_range;
    logic        r_err_surr;
`ifdef UTF16_BOM_EN
    logic        r_bom_pend;
    logic        w_bom;
`endif

    logic        w_accept;
    logic        w_xfer;
    logic        w_bad_range;
    logic        w_bad_surr;
    logic        w_supp;
    logic [3:0]  w_plane_m1;
    logic [15:0] w_unit_hi;
    logic [15:0] w_unit_lo;

    function automatic logic [7:0] f_first(input logic [15:0] u, input logic b);
        return b ? u[15:8] : u[7:0];
    endfunction

    function automatic logic [7:0] f_second(input logic [15:0] u, input logic b);
        return b ? u[7:0] : u[15:8];
    endfunction

    assign w_accept = bus.cp_valid & (r_state == IDLE);
    assign w_xfer   = r_byte_valid & bus.byte_ready;

    assign w_bad_range = (bus.cp_data > 32'h0010_FFFF);
    assign w_bad_surr  = (bus.cp_data >= 32'h0000_D800) && (bus.cp_data <= 32'h0000_DFFF);
    assign w_supp      = !w_bad_range && (bus.cp_data >= 32'h0001_0000);

    // v = cp - 0x10000 only touches the plane bits. cp[20:16] is 1..16 here, and taking
    // cp[19:16]-1 modulo 16 yields plane-1 for all of them (16 wraps 0 -> 15).
    assign w_plane_m1 = bus.cp_data[19:16] - 4'd1;

    always_comb begin
        w_unit_hi = bus.cp_data[15:0];
        w_unit_lo = {6'b110111, bus.cp_data[9:0]};
        if (w_bad_range || w_bad_surr) begin
            w_unit_hi = 16'hFFFD;
        end else if (w_supp) begin
            w_unit_hi = {6'b110110, w_plane_m1, bus.cp_data[15:10]};
        end
    end

`ifdef UTF16_BOM_EN
    // A request in the accept cycle applies to that same code point.
    assign w_bom = r_bom_pend | bom_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_hi         <= 16'h0000;
            r_lo         <= 16'h0000;
            r_supp       <= 1'b0;
            r_be         <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= 8'h00;
`ifdef UTF16_BOM_EN
            r_bom_pend   <= 1'b1;
`endif
        end else begin
`ifdef UTF16_BOM_EN
            if (w_accept) begin
                r_bom_pend <= 1'b0;
            end else if (bom_req) begin
                r_bom_pend <= 1'b1;
            end
`endif
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_hi         <= w_unit_hi;
                        r_lo         <= w_unit_lo;
                        r_supp       <= w_supp;
                        r_be         <= bus.be;
                        r_byte_valid <= 1'b1;
`ifdef UTF16_BOM_EN
                        if (w_bom) begin
                            r_state     <= BOM0;
                            r_byte_data <= f_first(16'hFEFF, bus.be);
                        end else begin
                            r_state     <= U0;
                            r_byte_data <= f_first(w_unit_hi, bus.be);
                        end
`else
                        r_state      <= U0;
                        r_byte_data  <= f_first(w_unit_hi, bus.be);
`endif
                    end
                end
`ifdef UTF16_BOM_EN
                BOM0: begin
                    if (w_xfer) begin
                        r_state     <= BOM1;
                        r_byte_data <= f_second(16'hFEFF, r_be);
                    end
                end
                BOM1: begin
                    if (w_xfer) begin
                        r_state     <= U0;
                        r_byte_data <= f_first(r_hi, r_be);
                    end
                end
`endif
                U0: begin
                    if (w_xfer) begin
                        r_state     <= U1;
                        r_byte_data <= f_second(r_hi, r_be);
                    end
                end
                U1: begin
                    if (w_xfer) begin
                        if (r_supp) begin
                            r_state     <= U2;
                            r_byte_data <= f_first(r_lo, r_be);
                        end else begin
                            r_state      <= IDLE;
                            r_byte_valid <= 1'b0;
                            r_byte_data  <= 8'h00;
                        end
                    end
                end
                U2: begin
                    if (w_xfer) begin
                        r_state     <= U3;
                        r_byte_data <= f_second(r_lo, r_be);
                    end
                end
                U3: begin
                    if (w_xfer) begin
                        r_state      <= IDLE;
                        r_byte_valid <= 1'b0;
                        r_byte_data  <= 8'h00;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_byte_valid <= 1'b0;
                    r_byte_data  <= 8'h00;
                end
            endcase
        end
    end

    // Sticky flags: clear first, then OR in a new error so a simultaneous error survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_range <= 1'b0;
            r_err_surr  <= 1'b0;
        end else begin
            r_err_range <= (r_err_range & ~clr_err) | (w_accept & w_bad_range);
            r_err_surr  <= (r_err_surr  & ~clr_err) | (w_accept & w_bad_surr);
        end
    end

    assign bus.cp_ready   = (r_state == IDLE);
    assign bus.byte_valid = r_byte_valid;
    assign bus.byte_data  = r_byte_data;
    assign idle           = (r_state == IDLE);
    assign err_range      = r_err_range;
    assign err_surr       = r_err_surr;

endmodule

// File: tb/tb_utf16_byte_encoder.sv
// Self-checking bench for utf16_byte_encoder: directed cases plus randomized code points
// compared against a UTF-16 reference model computed with plain arithmetic.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_utf16_byte_encoder;
    logic clk = 1'b0;
    logic rst;
    logic idle;
    logic clr_err;
    logic err_range;
    logic err_surr;
`ifdef UTF16_BOM_EN
    logic bom_req;
`endif

    always #5 clk = ~clk;

    utf16_byte_encoder_if bus ();

    utf16_byte_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .idle      (idle),
        .clr_err   (clr_err),
        .err_range (err_range),
        .err_surr  (err_surr)
`ifdef UTF16_BOM_EN
        ,
        .bom_req   (bom_req)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit m_err_range = 0;
    bit m_err_surr  = 0;
    bit m_bom_pend  = 1;

    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: code point -> list of 16-bit units -> bytes in the requested order.
    function automatic void build_expect(input logic [31:0] cp, input bit big, input bit bom);
        int unsigned units[$];
        int unsigned c;
        int unsigned v;
        exp_q.delete();
        if (bom) units.push_back(32'hFEFF);
        if (cp > 32'h10FFFF || (cp >= 32'hD800 && cp <= 32'hDFFF)) c = 32'hFFFD;
        else c = cp;
        if (c < 32'h10000) begin
            units.push_back(c);
        end else begin
            v = c - 32'h10000;
            units.push_back(32'hD800 + v / 1024);
            units.push_back(32'hDC00 + v % 1024);
        end
        foreach (units[i]) begin
            if (big) begin
                exp_q.push_back(8'(units[i] / 256));
                exp_q.push_back(8'(units[i] % 256));
            end else begin
                exp_q.push_back(8'(units[i] % 256));
                exp_q.push_back(8'(units[i] / 256));
            end
        end
    endfunction

    // Offers one code point at a falling edge and drains its bytes.
    // mode: 0 always ready, 1 random ready, 2 ready low 3 cycles before every byte.
    // abort_at >= 0 pulses rst once that many bytes have been transferred.
    task automatic send(input logic [31:0] cp, input bit big, input int mode,
                        input bit clr, input bit breq, input int abort_at);
        bit         bom;
        int         idx;
        int         cyc;
        int         lowcnt;
        bit         stalled;
        bit         rdy;
        logic [7:0] held;
        bom = 0;
`ifdef UTF16_BOM_EN
        bom = m_bom_pend | breq;
        m_bom_pend = 0;
`endif
        build_expect(cp, big, bom);
        if (clr) begin
            m_err_range = 0;
            m_err_surr  = 0;
        end
        if (cp > 32'h10FFFF) m_err_range = 1;
        else if (cp >= 32'hD800 && cp <= 32'hDFFF) m_err_surr = 1;

        bus.cp_valid = 1'b1;
        bus.cp_data  = cp;
        bus.be       = big;
        clr_err      = clr;
`ifdef UTF16_BOM_EN
        bom_req      = breq;
`endif
        @(posedge clk);
        @(negedge clk);
        bus.cp_valid = 1'b0;
        bus.cp_data  = $urandom;
        bus.be       = 1'($urandom_range(0, 1));
        clr_err      = 1'b0;
`ifdef UTF16_BOM_EN
        bom_req      = 1'b0;
`endif
        check("err_range_at_accept", err_range, m_err_range);
        check("err_surr_at_accept", err_surr, m_err_surr);

        idx = 0; cyc = 0; lowcnt = 0; stalled = 0; held = 8'h00;
        while (idx < exp_q.size() && cyc < 400) begin
            if (abort_at >= 0 && idx == abort_at) begin
                rst = 1'b1;
                #1;
                check("rst_byte_valid", bus.byte_valid, 0);
                check("rst_byte_data", bus.byte_data, 0);
                check("rst_idle", idle, 1);
                check("rst_cp_ready", bus.cp_ready, 1);
                check("rst_err_range", err_range, 0);
                check("rst_err_surr", err_surr, 0);
                m_err_range = 0;
                m_err_surr  = 0;
                m_bom_pend  = 1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            check("byte_valid", bus.byte_valid, 1);
            check("cp_ready_busy", bus.cp_ready, 0);
            if (stalled) check("stall_hold", bus.byte_data, held);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 2) != 0);
                default: rdy = (lowcnt >= 3);
            endcase
            bus.byte_ready = rdy;
            if (bus.byte_valid && rdy) begin
                check($sformatf("byte[%0d] cp=%0h be=%0d", idx, cp, big), bus.byte_data, exp_q[idx]);
                idx++;
                stalled = 0;
                lowcnt  = 0;
            end else begin
                stalled = 1;
                held    = bus.byte_data;
                lowcnt++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if (idx < exp_q.size()) check("byte_count_timeout", idx, exp_q.size());
        bus.byte_ready = 1'($urandom_range(0, 1));
        check("byte_valid_after", bus.byte_valid, 0);
        check("idle_after", idle, 1);
        check("cp_ready_after", bus.cp_ready, 1);
        check("err_range", err_range, m_err_range);
        check("err_surr", err_surr, m_err_surr);
    endtask

    task automatic clear_flags();
        clr_err = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_err = 1'b0;
        m_err_range = 0;
        m_err_surr  = 0;
        check("clr_err_range", err_range, 0);
        check("clr_err_surr", err_surr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cp;
        rst            = 1'b1;
        bus.cp_valid   = 1'b0;
        bus.cp_data    = 32'h0;
        bus.be         = 1'b1;
        bus.byte_ready = 1'b0;
        clr_err        = 1'b0;
`ifdef UTF16_BOM_EN
        bom_req        = 1'b0;
`endif
        @(negedge clk);
        check("reset_byte_valid", bus.byte_valid, 0);
        check("reset_byte_data", bus.byte_data, 0);
        check("reset_idle", idle, 1);
        check("reset_cp_ready", bus.cp_ready, 1);
        check("reset_err_range", err_range, 0);
        check("reset_err_surr", err_surr, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic encodings (with the BOM build, the first one carries FE FF).
        send(32'h0000_0041, 1, 0, 0, 0, -1);
        send(32'h0000_0042, 1, 0, 0, 0, -1);
        send(32'h0000_0041, 0, 0, 0, 0, -1);
        send(32'h0000_20AC, 1, 0, 0, 0, -1);
        send(32'h0001_F600, 1, 0, 0, 0, -1);
        send(32'h0001_F600, 0, 0, 0, 0, -1);
        send(32'h0000_0043, 0, 0, 0, 1, -1);
        send(32'h0000_0000, 1, 0, 0, 0, -1);
        send(32'h0000_FFFF, 0, 0, 0, 0, -1);
        send(32'h0001_0000, 1, 0, 0, 0, -1);

        // Invalid input and sticky flags.
        send(32'h0011_0000, 1, 0, 0, 0, -1);
        send(32'h0000_D800, 1, 0, 0, 0, -1);
        send(32'h0000_DFFF, 0, 1, 0, 0, -1);
        clear_flags();
        send(32'hFFFF_FFFF, 1, 0, 1, 0, -1);
        clear_flags();

        // Backpressure, then reset in the middle of a supplementary code point.
        send(32'h0010_FFFF, 1, 2, 0, 0, -1);
        send(32'h0010_FFFF, 1, 2, 0, 0, 2);
        send(32'h0000_0041, 1, 0, 0, 0, -1);
        send(32'h0010_FFFF, 0, 1, 0, 0, -1);

        // Randomized code points, byte orders, backpressure and clears.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0:       cp = $urandom_range(0, 32'hFFFF);
                1:       cp = $urandom_range(32'h10000, 32'h10FFFF);
                2:       cp = $urandom_range(32'hD800, 32'hDFFF);
                3:       cp = $urandom_range(32'h110000, 32'h7FFFFFFF);
                default: cp = $urandom;
            endcase
            send(cp, 1'($urandom_range(0, 1)), $urandom_range(0, 1),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/utf16_byte_encoder.md
Name: utf16_byte_encoder

Overview:
Downstream stage of the UTF-8 codec. It consumes one decoded Unicode code point at a time and emits that code point as a stream of UTF-16 bytes, big- or little-endian, on a valid/ready byte interface. Supplementary-plane code points (above U+FFFF) are split into surrogate pairs. Invalid input is replaced with U+FFFD and flagged with sticky error bits.

Parameters:
None.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
cp_valid  input  1  code point offered
cp_ready  output  1  encoder can accept a code point this cycle
cp_data  input  32  code point; full 32 bits are checked for range
be  input  1  1 = big-endian output, 0 = little-endian; sampled on accept
byte_valid  output  1  byte_data holds a valid byte
byte_ready  input  1  consumer accepts the byte
byte_data  output  8  output byte
idle  output  1  no code point in progress
clr_err  input  1  synchronous clear of the sticky error flags
err_range  output  1  sticky: a code point above 0x10FFFF was received
err_surr  output  1  sticky: a code point in 0xD800..0xDFFF was received

Behaviour:
- Reset (asynchronous, any time, including mid-code-point):
  - State goes to IDLE; any pending bytes are discarded.
  - byte_valid=0, byte_data=0x00, err_range=0, err_surr=0, idle=1, cp_ready=1.
- State machine: IDLE, U0, U1, U2, U3 (plus BOM0, BOM1 when the feature is enabled).
  - cp_ready = (state==IDLE). The ready path has no combinational dependency on byte_ready.
- Accept: when cp_valid & cp_ready, the encoder latches cp_data and be.
  - byte_valid rises on the next cycle, with the first byte already on byte_data.
- Classification at accept:
  - cp > 0x10FFFF: set err_range; encode U+FFFD.
  - 0xD800 <= cp <= 0xDFFF: set err_surr; encode U+FFFD.
  - cp <= 0xFFFF (otherwise): one unit u = cp[15:0], sent in states U0 and U1.
  - 0x10000 <= cp <= 0x10FFFF: v = cp - 0x10000 (20 bits); hi = 0xD800 | v[19:10]; lo = 0xDC00 | v[9:0]; sent in states U0 through U3.
- Byte order:
  - be=1: unit MSB then LSB; hi unit before lo unit.
  - be=0: unit LSB then MSB; hi unit still before lo unit.
- Handshake:
  - A byte transfers on byte_valid & byte_ready.
  - byte_data and byte_valid hold stable while byte_ready is low.
  - The state advances only on a transfer.
  - After the last byte transfers, the encoder returns to IDLE with byte_valid=0.
  - Throughput: one bubble cycle between code points.
  - BMP code point: 3 cycles per code point minimum. Supplementary code point: 5 cycles minimum.
- idle = (state==IDLE).
- Error flags:
  - A flag sets on the accept edge.
  - clr_err clears both flags on the next edge.
  - Simultaneous clr_err and a new error: set wins.
  - Flags never clear on their own.
- Changes to be while a code point is in progress have no effect until the next accept.

Optional Feature:
Macro UTF16_BOM_EN.
- Enabled:
  - After reset, the first accepted code point is preceded by a byte-order mark: FE FF when be=1, FF FE when be=0.
  - The mark is sent from states BOM0 and BOM1, which go to U0 afterward. Same handshake rules apply.
  - A bom_req input port (1 bit) re-arms the mark for the next accepted code point.
  - bom_req asserted during the same cycle as an accept applies to that accept.
- Disabled:
  - No BOM states, no bom_req port.
  - The first byte after an accept is always the first data byte.

Test Plan:
- U+0041, be=1, byte_ready=1 -> bytes 00 41 on consecutive cycles starting one cycle after accept; idle=1 afterwards; no error flags.
- U+0041, be=0 -> 41 00. U+20AC, be=1 -> 20 AC.
- U+1F600, be=1 -> D8 3D DE 00. Same code point with be=0 -> 3D D8 00 DE.
- Invalid code points, be=1:
  - 0x00110000 -> FF FD, err_range=1.
  - Then U+D800 -> FF FD, err_surr=1, err_range still 1.
  - Then clr_err -> both 0.
  - clr_err in the same cycle as accepting 0xFFFFFFFF -> err_range=1.
- Backpressure and reset:
  - U+10FFFF, be=1, byte_ready low 3 cycles on each byte -> DB FF DF FF, byte_data stable during stalls, cp_ready=0 throughout.
  - rst pulsed after the second byte -> byte_valid=0 immediately, next code point starts fresh.
- With UTF16_BOM_EN:
  - After reset, U+0041, be=1 -> FE FF 00 41; second code point U+0042 -> 00 42 only.
  - bom_req then U+0043, be=0 -> FF FE 43 00.
